fifo_block_writer: RTL

- Producer-side packer feeding the block FIFO's producer port.
- Takes a valid/ready word stream, writes consecutive words into the current block through p_write/p_addr/p_data, and pulses p_push to commit the block when it is full or the stream marks end-of-frame.
- Respects FIFO back-pressure via p_request/status_full.
- Single clock domain (producer side).

---
 rtl/fifo_block_pkg.sv | 37 +++
 rtl/fifo_block_writer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/fifo_block_pkg.sv
// fifo_block_pkg
//   Shared definitions for the block FIFO producer-side writer and the
//   matching consumer-side reader.
//   - Width derivation helpers (data width, word-address width, block words)
//   - state_t: writer/reader FSM states {IDLE, FILL, PAD, PUSH}
//   PAD is only reachable when FIFO_BLOCK_WRITER_PAD_EN is defined.
package fifo_block_pkg;

    localparam int DEFAULT_BLK_ADDR_WIDTH = 14;
    localparam int DEFAULT_WORD_BWIDTH    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        PAD  = 2'd2,
        PUSH = 2'd3
    } state_t;

    // Word of 2^word_bwidth bytes.
    function automatic int calc_data_width(input int word_bwidth);
        return 8 * (2 ** word_bwidth);
    endfunction

    // Word-address width inside one block.
    function automatic int calc_addr_width(input int blk_addr_width, input int word_bwidth);
        return blk_addr_width - word_bwidth;
    endfunction

    // Number of words in one block.
    function automatic int calc_blk_words(input int addr_width);
        return 2 ** addr_width;
    endfunction

    localparam int BLK_WORDS = calc_blk_words(
        calc_addr_width(DEFAULT_BLK_ADDR_WIDTH, DEFAULT_WORD_BWIDTH));

endpackage

// File: rtl/fifo_block_writer.sv
// fifo_block_writer
//   Packs a valid/ready word stream into blocks of the block FIFO. Words are
//   written one per accept through p_write/p_addr/p_data; the block is
//   committed with a one-cycle p_push when it is full or s_last is seen.
//
//   Handshake: a word transfers on a rising edge where s_valid && s_ready.
//   s_ready is a pure decode of the FILL state; s_valid may be asserted at
//   any time and must hold data stable until accepted.
//
//   Ports:
//     p_clk, p_rst         clock, synchronous active-high reset
//     s_valid/s_ready      input stream handshake, s_data word, s_last end of frame
//     p_request            FIFO can take a new block
//     status_full          FIFO has no free block
//     p_write/p_addr/p_data  registered word write into the current block
//     p_push, p_len        block commit pulse and its word count
//     frame_len            real pre-pad word count (FIFO_BLOCK_WRITER_PAD_EN only)
//     blk_cnt              blocks pushed since reset, wraps
//     dbg_state            current FSM state for observation
//
//   Build option FIFO_BLOCK_WRITER_PAD_EN: short frames are padded with zero
//   words up to a full block before the commit.
module fifo_block_writer
    import fifo_block_pkg::*;
#(
    parameter  int BLK_ADDR_WIDTH = 14,
    parameter  int WORD_BWIDTH    = 3,
    localparam int DATA_WIDTH     = calc_data_width(WORD_BWIDTH),
    localparam int ADDR_WIDTH     = calc_addr_width(BLK_ADDR_WIDTH, WORD_BWIDTH),
    localparam int BLK_WORDS      = calc_blk_words(ADDR_WIDTH)
) (
    input  logic                  p_clk,
    input  logic                  p_rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    input  logic                  p_request,
    input  logic                  status_full,
    output logic                  p_write,
    output logic [ADDR_WIDTH-1:0] p_addr,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  p_push,
    output logic [ADDR_WIDTH:0]   p_len,
    output logic [31:0]           blk_cnt,
`ifdef FIFO_BLOCK_WRITER_PAD_EN
    output logic [ADDR_WIDTH:0]   frame_len,
`endif
    output logic [1:0]            dbg_state
);

    localparam logic [ADDR_WIDTH:0] LAST_W   = (ADDR_WIDTH+1)'(BLK_WORDS - 1);
    localparam logic [ADDR_WIDTH:0] FULL_LEN = (ADDR_WIDTH+1)'(BLK_WORDS);

    state_t                state_q;
    logic [ADDR_WIDTH:0]   wcnt_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic                  p_write_q;
    logic [ADDR_WIDTH-1:0] p_addr_q;
    logic [DATA_WIDTH-1:0] p_data_q;
    logic                  p_push_q;
    logic [ADDR_WIDTH:0]   p_len_q;
    logic [31:0]           blk_cnt_q;
`ifdef FIFO_BLOCK_WRITER_PAD_EN
    logic [ADDR_WIDTH:0]   frame_len_q;
`endif

    always_ff @(posedge p_clk) begin
        if (p_rst) begin
            state_q     <= IDLE;
            wcnt_q      <= '0;
            len_q       <= '0;
            p_write_q   <= 1'b0;
            p_addr_q    <= '0;
            p_data_q    <= '0;
            p_push_q    <= 1'b0;
            p_len_q     <= '0;
            blk_cnt_q   <= '0;
`ifdef FIFO_BLOCK_WRITER_PAD_EN
            frame_len_q <= '0;
`endif
        end else begin
            p_push_q <= 1'b0;
            case (state_q)
                // p_push_q blocks the grant for the commit cycle so the FIFO
                // status reflects the block just pushed.
                IDLE: begin
                    if (p_request && !status_full && !p_push_q) begin
                        state_q <= FILL;
                    end
                end
                FILL: begin
                    p_write_q <= 1'b0;
                    if (s_valid) begin
                        p_write_q <= 1'b1;
                        p_addr_q  <= wcnt_q[ADDR_WIDTH-1:0];
                        p_data_q  <= s_data;
                        wcnt_q    <= wcnt_q + 1'b1;
                        if (wcnt_q == LAST_W || s_last) begin
                            len_q <= wcnt_q + 1'b1;
`ifdef FIFO_BLOCK_WRITER_PAD_EN
                            state_q <= (wcnt_q == LAST_W) ? PUSH : PAD;
`else
                            state_q <= PUSH;
`endif
                        end
                    end
                end
`ifdef FIFO_BLOCK_WRITER_PAD_EN
                // Zero-fill the rest of the block, one word per cycle.
                PAD: begin
                    p_write_q <= 1'b1;
                    p_addr_q  <= wcnt_q[ADDR_WIDTH-1:0];
                    p_data_q  <= '0;
                    wcnt_q    <= wcnt_q + 1'b1;
                    if (wcnt_q == LAST_W) begin
                        state_q <= PUSH;
                    end
                end
`endif
                // The last word's write is visible during this cycle.
                PUSH: begin
                    p_write_q   <= 1'b0;
                    p_push_q    <= 1'b1;
`ifdef FIFO_BLOCK_WRITER_PAD_EN
                    p_len_q     <= FULL_LEN;
                    frame_len_q <= len_q;
`else
                    p_len_q     <= len_q;
`endif
                    blk_cnt_q   <= blk_cnt_q + 32'd1;
                    wcnt_q      <= '0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_ready   = (state_q == FILL);
    assign p_write   = p_write_q;
    assign p_addr    = p_addr_q;
    assign p_data    = p_data_q;
    assign p_push    = p_push_q;
    assign p_len     = p_len_q;
    assign blk_cnt   = blk_cnt_q;
    assign dbg_state = state_q;
`ifdef FIFO_BLOCK_WRITER_PAD_EN
    assign frame_len = frame_len_q;
`else
    // Full-block length constant only matters to the padded build.
    logic unused_full_len;
    assign unused_full_len = ^FULL_LEN;
`endif

endmodule
